// File: rtl/attrib_palette.sv
// Attribute/palette stage: text or graphics index -> programmable palette -> colour,
// with character blink, cursor, overscan and sync blanking over a two-stage pipeline.
module attrib_palette #(
    parameter int PIX_BITS  = 4,
    parameter int OUT_BITS  = 6,
    parameter int BLINK_DIV = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pal_we,
    input  logic [PIX_BITS-1:0] pal_addr,
    input  logic [OUT_BITS-1:0] pal_wdata,
    input  logic [OUT_BITS-1:0] overscan,
    input  logic                text_mode,
    input  logic                blink_enabled,
    input  logic                blink,
    input  logic [7:0]          att_byte,
    input  logic                pix_in,
    input  logic                cursor,
    input  logic [PIX_BITS-1:0] gfx_idx,
    input  logic                display_enable,
    input  logic                hsync,
    input  logic                vsync,
    input  logic                pix_valid,
    output logic [OUT_BITS-1:0] pix_out,
    output logic                pix_out_valid
);

    localparam int PAL_N = 1 << PIX_BITS;
    localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

    logic [OUT_BITS-1:0] pal [PAL_N];

    logic [1:0]       bhist;
    logic [CNT_W-1:0] bcnt;
    logic             cphase;
    logic             blink_rise;

    logic [3:0]          fg;
    logic [3:0]          bg;
    logic                blink_ok;
    logic                dot;
    logic [PIX_BITS-1:0] idx_d;

    logic [PIX_BITS-1:0] idx0;
    logic                border0;
    logic                blank0;
    logic                v0;

    // NOTE: the palette is a register array with a reset value, so it cannot map to RAM;
    // the identity reset is what makes the stage usable before software programs it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PAL_N; i++) begin
                pal[i] <= OUT_BITS'(i);
            end
        end else if (pal_we) begin
            pal[pal_addr] <= pal_wdata;
        end
    end

    assign blink_rise = (bhist == 2'b01);

    // NOTE: state is updated with <= so every flop samples pre-edge values; with = the
    // read of pal[idx0] in stage 1 would depend on process order during a write collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bhist  <= 2'b00;
            bcnt   <= '0;
            cphase <= 1'b0;
        end else begin
            bhist <= {bhist[0], blink};
            if (blink_rise) begin
                if (bcnt == CNT_MAX) begin
                    bcnt   <= '0;
                    cphase <= ~cphase;
                end else begin
                    bcnt <= bcnt + 1'b1;
                end
            end
        end
    end

    // NOTE: every signal below is assigned on all paths, so no latch is inferred.
    always_comb begin
        fg       = att_byte[3:0];
        bg       = blink_enabled ? {1'b0, att_byte[6:4]} : att_byte[7:4];
        blink_ok = ~(blink_enabled & att_byte[7] & ~cursor) | ~cphase;
        dot      = (pix_in & blink_ok) | (cursor & blink);
        idx_d    = text_mode ? PIX_BITS'(dot ? fg : bg) : gfx_idx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx0    <= '0;
            border0 <= 1'b1;
            blank0  <= 1'b0;
            v0      <= 1'b0;
        end else begin
            idx0    <= idx_d;
            border0 <= ~display_enable;
            blank0  <= hsync | vsync;
            v0      <= pix_valid;
        end
    end

    // Overscan bypasses the palette; sync blanking overrides everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_out       <= '0;
            pix_out_valid <= 1'b0;
        end else begin
            pix_out       <= blank0 ? '0 : (border0 ? overscan : pal[idx0]);
            pix_out_valid <= v0;
        end
    end

endmodule

// File: tb/tb_attrib_palette.sv
// Self-checking bench for attrib_palette: directed cases plus randomized traffic against
// a cycle-level behavioural model of palette, blink phase and output priority.
module tb_attrib_palette;

    localparam int PIX_BITS  = 4;
    localparam int OUT_BITS  = 6;
    localparam int BLINK_DIV = 2;
    localparam int PAL_N     = 1 << PIX_BITS;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                pal_we;
    logic [PIX_BITS-1:0] pal_addr;
    logic [OUT_BITS-1:0] pal_wdata;
    logic [OUT_BITS-1:0] overscan;
    logic                text_mode;
    logic                blink_enabled;
    logic                blink;
    logic [7:0]          att_byte;
    logic                pix_in;
    logic                cursor;
    logic [PIX_BITS-1:0] gfx_idx;
    logic                display_enable;
    logic                hsync;
    logic                vsync;
    logic                pix_valid;
    logic [OUT_BITS-1:0] pix_out;
    logic                pix_out_valid;

    int total = 0;
    int bad   = 0;

    // Model state: palette contents, count of blink rises seen, last two sampled blink
    // levels, and the pixel currently held between the two pipeline stages.
    int pal_m [PAL_N];
    int rises;
    int b_prev1, b_prev2;
    int s_idx, s_border, s_blank, s_v;

    always #5 clk = ~clk;

    attrib_palette #(
        .PIX_BITS (PIX_BITS),
        .OUT_BITS (OUT_BITS),
        .BLINK_DIV(BLINK_DIV)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pal_we        (pal_we),
        .pal_addr      (pal_addr),
        .pal_wdata     (pal_wdata),
        .overscan      (overscan),
        .text_mode     (text_mode),
        .blink_enabled (blink_enabled),
        .blink         (blink),
        .att_byte      (att_byte),
        .pix_in        (pix_in),
        .cursor        (cursor),
        .gfx_idx       (gfx_idx),
        .display_enable(display_enable),
        .hsync         (hsync),
        .vsync         (vsync),
        .pix_valid     (pix_valid),
        .pix_out       (pix_out),
        .pix_out_valid (pix_out_valid)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < PAL_N; i++) pal_m[i] = i;
        rises    = 0;
        b_prev1  = 0;
        b_prev2  = 0;
        s_idx    = 0;
        s_border = 1;
        s_blank  = 0;
        s_v      = 0;
    endtask

    task automatic idle_inputs();
        pal_we = 0; pal_addr = '0; pal_wdata = '0; overscan = '0;
        text_mode = 0; blink_enabled = 0; blink = 0; att_byte = '0;
        pix_in = 0; cursor = 0; gfx_idx = '0; display_enable = 1;
        hsync = 0; vsync = 0; pix_valid = 0;
    endtask

    // One clock with the inputs currently driven; called at a negedge, returns at the next.
    task automatic step();
        int exp_out, exp_valid, phase, fg, bg, dot, n_idx;
        bit char_off;
        exp_out   = s_blank ? 0 : (s_border ? int'(overscan) : pal_m[s_idx]);
        exp_valid = s_v;

        phase    = (rises / BLINK_DIV) % 2;
        fg       = att_byte[3:0];
        bg       = blink_enabled ? int'(att_byte[6:4]) : int'(att_byte[7:4]);
        char_off = blink_enabled && att_byte[7] && !cursor && (phase == 1);
        dot      = ((pix_in && !char_off) || (cursor && blink)) ? 1 : 0;
        n_idx    = text_mode ? (dot ? fg : bg) : int'(gfx_idx);

        @(posedge clk);
        if (pal_we) pal_m[pal_addr] = pal_wdata;
        if (b_prev2 == 0 && b_prev1 == 1) rises++;
        b_prev2 = b_prev1;
        b_prev1 = blink;

        @(negedge clk);
        check("pix_out", pix_out, exp_out);
        check("pix_out_valid", pix_out_valid, exp_valid);

        s_idx    = n_idx;
        s_border = display_enable ? 0 : 1;
        s_blank  = (hsync || vsync) ? 1 : 0;
        s_v      = pix_valid;
    endtask

    task automatic fresh_reset();
        @(negedge clk);
        rst_n = 0;
        idle_inputs();
        @(negedge clk);
        rst_n = 1;
        model_reset();
    endtask

    task automatic blink_pulse();
        blink = 1;
        repeat (3) step();
        blink = 0;
        repeat (3) step();
    endtask

    logic [3:0] vpat;
    logic [4:0] vobs;

    initial begin
        rst_n = 0;
        idle_inputs();

        // Reset held with random inputs: outputs stay zero.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            {pal_we, text_mode, blink, pix_in, cursor, pix_valid, hsync} = 7'($urandom);
            att_byte = 8'($urandom); gfx_idx = PIX_BITS'($urandom);
            pal_wdata = OUT_BITS'($urandom); overscan = OUT_BITS'($urandom);
            @(posedge clk); #1;
            check("reset_pix_out", pix_out, 0);
            check("reset_valid", pix_out_valid, 0);
        end
        @(negedge clk);
        idle_inputs();
        rst_n = 1;
        model_reset();

        // First graphics pixel after release.
        gfx_idx = 5; pix_valid = 1;
        step(); step();
        check("gfx_after_reset", pix_out, 5);

        // Text colours.
        text_mode = 1; att_byte = 8'h1E; pix_in = 1;
        step(); step();
        check("text_fg", pix_out, 14);
        pix_in = 0;
        step(); step();
        check("text_bg", pix_out, 1);
        att_byte = 8'h9E; blink_enabled = 0;
        step(); step();
        check("text_bg_intensity", pix_out, 9);

        // Border and blanking.
        display_enable = 0; overscan = 6'h3F;
        step(); step();
        check("border", pix_out, 6'h3F);
        hsync = 1;
        step(); step();
        check("hsync_blank_text", pix_out, 0);
        hsync = 0; vsync = 1; text_mode = 0; display_enable = 1;
        step(); step();
        check("vsync_blank_gfx", pix_out, 0);
        vsync = 0;

        // Valid pipeline: pattern appears one step after being driven through two stages.
        vpat = 4'b1101;
        for (int i = 0; i < 5; i++) begin
            pix_valid = (i < 4) ? vpat[3-i] : 1'b0;
            step();
            vobs[i] = pix_out_valid;
        end
        for (int i = 0; i < 4; i++) check("valid_pattern", vobs[i+1], vpat[3-i]);

        // Palette write, then read-during-write collision on entry 3.
        pal_we = 1; pal_addr = 3; pal_wdata = 6'h2A;
        step();
        pal_we = 0; gfx_idx = 3;
        step(); step();
        check("pal_write", pix_out, 6'h2A);
        pal_we = 1; pal_wdata = 6'h15;
        step();
        check("pal_collision_old", pix_out, 6'h2A);
        pal_we = 0;
        step();
        check("pal_collision_new", pix_out, 6'h15);

        // Reset during a write restores identity.
        @(negedge clk);
        pal_we = 1; pal_addr = 3; pal_wdata = 6'h33;
        rst_n = 0;
        @(negedge clk);
        idle_inputs();
        rst_n = 1;
        model_reset();
        gfx_idx = 3;
        step(); step();
        check("pal_reset_identity", pix_out, 3);

        // Character blink with BLINK_DIV=2.
        fresh_reset();
        text_mode = 1; blink_enabled = 1; att_byte = 8'h8F; pix_in = 1;
        step(); step();
        check("blink_phase0", pix_out, 15);
        blink_pulse();
        check("blink_after_1", pix_out, 15);
        blink_pulse();
        check("blink_after_2", pix_out, 0);
        cursor = 1; blink = 1;
        step(); step();
        check("cursor_over_blink", pix_out, 15);
        cursor = 0; blink = 0;
        repeat (3) step();
        blink_pulse();
        blink_pulse();
        check("blink_after_4", pix_out, 15);

        // Randomized traffic with one asynchronous mid-frame reset.
        for (int i = 0; i < 800; i++) begin
            if (i == 400) begin
                #2 rst_n = 0;
                #1;
                check("async_reset_out", pix_out, 0);
                check("async_reset_valid", pix_out_valid, 0);
                @(negedge clk);
                rst_n = 1;
                model_reset();
            end
            pal_we         = ($urandom_range(7) == 0);
            pal_addr       = PIX_BITS'($urandom);
            pal_wdata      = OUT_BITS'($urandom);
            overscan       = OUT_BITS'($urandom);
            text_mode      = ($urandom_range(3) != 0);
            blink_enabled  = $urandom_range(1);
            att_byte       = 8'($urandom);
            pix_in         = $urandom_range(1);
            cursor         = ($urandom_range(5) == 0);
            gfx_idx        = PIX_BITS'($urandom);
            display_enable = ($urandom_range(7) != 0);
            hsync          = ($urandom_range(15) == 0);
            vsync          = ($urandom_range(31) == 0);
            pix_valid      = $urandom_range(1);
            if ($urandom_range(4) == 0) blink = ~blink;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/attrib_palette.md
# attrib_palette

Parametrised pixel attribute and palette stage for the video path. It sits between the character/graphics shifters and the DAC/scan-doubler. It converts text attribute dots or graphics pixel indices into final colour codes through a programmable palette, and it handles character blink, cursor, overscan and sync blanking. The output is registered through a fixed two-stage pipeline, where the previous generation used a combinational CGA-only output.

## Interface
Parameters:
- PIX_BITS, 4: index width. Legal range 4..8. The palette has 2**PIX_BITS entries.
- OUT_BITS, 6: width of each palette entry and of the output colour. Must be ≥ PIX_BITS.
- BLINK_DIV, 2: number of `blink` rising edges per character-blink phase toggle. Must be ≥ 1.

Ports:
- clk  in  1  system clock. This is the only clock.
- rst_n  in  1  reset. Asynchronous, active-low.
- pal_we  in  1  palette write strobe.
- pal_addr  in  PIX_BITS  palette entry to write.
- pal_wdata  in  OUT_BITS  palette write data.
- overscan  in  OUT_BITS  border colour, used directly without palette lookup.
- text_mode  in  1  1 = text attribute path, 0 = graphics index path.
- blink_enabled  in  1  1 = attribute bit 7 means blink and background is 3-bit; 0 = bit 7 is background intensity.
- blink  in  1  cursor blink square wave from the CRTC.
- att_byte  in  8  text attribute: [3:0] fg, [6:4] bg, [7] blink/intensity.
- pix_in  in  1  text glyph dot.
- cursor  in  1  cursor active at this pixel.
- gfx_idx  in  PIX_BITS  graphics pixel index.
- display_enable  in  1  active display area.
- hsync, vsync  in  1 each  sync pulses.
- pix_valid  in  1  input pixel strobe.
- pix_out  out  OUT_BITS  final colour.
- pix_out_valid  out  1  `pix_valid` delayed by 2 cycles.

## Operation
- Palette: register array. On reset, entry i = i zero-extended to OUT_BITS (identity).
  - When `pal_we`=1, `pal_wdata` is written to entry `pal_addr` at the rising clk edge.
- Blink divider:
  - `blink` is sampled by a 2-flop history; a rising edge is history == 01.
  - Each rising edge increments `bcnt`, range 0..BLINK_DIV-1.
  - When `bcnt` = BLINK_DIV-1, a rising edge wraps `bcnt` to 0 and toggles `cphase`.
  - Reset: history 00, `bcnt` 0, `cphase` 0.
- Stage 0 (index select, registered every cycle):
  - fg = att_byte[3:0].
  - bg = blink_enabled ? {0, att_byte[6:4]} : att_byte[7:4].
  - blink_ok = ~(blink_enabled & att_byte[7] & ~cursor) | ~cphase.
  - dot = (pix_in & blink_ok) | (cursor & blink).
  - Text index = dot ? fg : bg, zero-extended to PIX_BITS. Graphics index = gfx_idx.
  - Stage 0 also registers three flags:
    - border = ~display_enable
    - blank = hsync | vsync
    - v0 = pix_valid
- Stage 1 (output, registered):
  - pix_out = blank ? 0 : border ? overscan : pal[idx].
  - Priority is blank > border > palette.
  - pix_out_valid = v0.
- Stages advance every clk regardless of valid. `pix_valid` only qualifies the output and never stalls the pipeline.
- A change of `text_mode` takes effect on the next pixel. There is no mode-switch flush.

## Timing
- Latency: inputs at edge N appear on pix_out / pix_out_valid after edge N+2. Throughput is one pixel per clk.
- Reset values:
  - pix_out = 0, pix_out_valid = 0.
  - Stage-0 registers = 0, except border = 1.
  - Palette = identity.
  - Divider state = 0.
- Reset asserted mid-frame clears everything asynchronously. The first valid output is 2 cycles after the first sampled `pix_valid` following release.
- Palette write/read collision: stage 1 reading entry A in the same cycle A is written uses the old value. The new value is used from the next edge on.
- Simultaneous `pal_we` and reset: reset wins and the entry holds its identity value.
- Blink edge: a `blink` rising at edge N is detected at edge N+2, and `cphase` toggles at that edge. Pixels in stage 0 at that edge use the new phase.
- `cursor & blink` uses the raw `blink` input, not the delayed history.
- BLINK_DIV=1: `cphase` toggles on every rising edge, and `bcnt` stays 0.

## Test plan
- Reset: hold rst_n=0 with random inputs -> pix_out=0 and pix_out_valid=0 throughout. After release, with gfx_idx=5, display_enable=1, pix_valid=1 -> pix_out=5 two cycles later.
- Palette write: write entry 3 = 6'h2A, then drive gfx_idx=3, display_enable=1 -> pix_out=6'h2A at +2 cycles. Collision case: write entry 3 = 6'h15 while idx 3 is in stage 1 -> that output is 6'h2A, the next output is 6'h15.
- Text colours: att_byte=8'h1E, pix_in=1 -> pal[14]; pix_in=0 -> pal[1].
  - With blink_enabled=0 and att_byte=8'h9E, pix_in=0 -> pal[9].
- Character blink: BLINK_DIV=2, blink_enabled=1, att_byte=8'h8F, pix_in=1.
  - Output is pal[15] until the 2nd blink rising edge, then pal[0].
  - After the 4th rising edge it returns to pal[15].
  - With cursor=1 and blink=1, the output is pal[15] regardless of phase.
- Blank/border: display_enable=0, overscan=6'h3F -> 6'h3F. Asserting hsync or vsync in any mode -> 0.
- Valid pipeline: pix_valid pattern 1,0,1,1 -> pix_out_valid shows 1,0,1,1 delayed by exactly 2 cycles.
